// File: rtl/j1a_bus_pkg.sv
// rtl/j1a_bus_pkg.sv - shared widths and FSM encoding for the J1A memory responder
package j1a_bus_pkg;

   localparam int ADR_W     = 15;
   localparam int DAT_W     = 16;
   localparam int INS_ADR_W = 13;
   localparam int WAIT_W    = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_IFETCH = 3'd1,
      ST_DECIDE = 3'd2,
      ST_DREAD  = 3'd3,
      ST_WSETUP = 3'd4,
      ST_WPULSE = 3'd5,
      ST_WHOLD  = 3'd6,
      ST_ACK    = 3'd7
   } state_t;

endpackage

// File: rtl/j1a_wait_timer.sv
// rtl/j1a_wait_timer.sv - loadable down-counter timing the SRAM access phases
module j1a_wait_timer
   import j1a_bus_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [WAIT_W-1:0] load_val,
   output logic              done
);

   logic [WAIT_W-1:0] cnt_q;

   // Load on phase entry, then count down and park at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/j1a_mem_responder.sv
// rtl/j1a_mem_responder.sv - serialises J1A fetch and data cycles onto one async SRAM port
module j1a_mem_responder
   import j1a_bus_pkg::*;
#(
   parameter int unsigned      WAIT_RD  = 2,
   parameter int unsigned      WAIT_WR  = 2,
   parameter logic [ADR_W-1:0] INS_BASE = 15'h0000
) (
   input  logic                 sys_clk_i,
   input  logic                 sys_res_ni,
   input  logic                 shr_stb_i,
   output logic                 shr_ack_o,
   input  logic                 ins_cyc_i,
   input  logic [INS_ADR_W-1:0] ins_adr_i,
   output logic [DAT_W-1:0]     ins_dat_o,
   input  logic                 dat_cyc_i,
   input  logic                 dat_we_i,
   input  logic [ADR_W-1:0]     dat_adr_i,
   input  logic [DAT_W-1:0]     dat_dat_i,
   output logic [DAT_W-1:0]     dat_dat_o,
   output logic [ADR_W-1:0]     mem_adr_o,
   output logic [DAT_W-1:0]     mem_dat_o,
   input  logic [DAT_W-1:0]     mem_dat_i,
   output logic                 mem_ce_no,
   output logic                 mem_oe_no,
   output logic                 mem_we_no
);

   localparam logic [WAIT_W-1:0] RD_LOAD = WAIT_W'(WAIT_RD);
   localparam logic [WAIT_W-1:0] WR_LOAD = WAIT_W'(WAIT_WR);

   state_t             state_q, state_d;
   logic               tmr_load;
   logic [WAIT_W-1:0]  tmr_val;
   logic               tmr_done;
   logic [ADR_W-1:0]   wr_adr_q;
   logic [DAT_W-1:0]   wr_dat_q;
   logic               wr_drop_q;
   logic [ADR_W-1:0]   ins_mem_adr;

   // Address wraps modulo 2^15 by virtue of the 15-bit sum
   assign ins_mem_adr = INS_BASE + {{(ADR_W-INS_ADR_W){1'b0}}, ins_adr_i};

   j1a_wait_timer u_wait_timer (
      .clk      (sys_clk_i),
      .rst_n    (sys_res_ni),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // State register
   always_ff @(posedge sys_clk_i or negedge sys_res_ni) begin
      if (!sys_res_ni) state_q <= ST_IDLE;
      else             state_q <= state_d;
   end

   // Next state and timer load; reads abort on a dropped strobe, writes run to completion
   always_comb begin
      state_d  = state_q;
      tmr_load = 1'b0;
      tmr_val  = RD_LOAD;
      case (state_q)
         ST_IDLE: begin
            if (shr_stb_i && ins_cyc_i) begin
               state_d  = ST_IFETCH;
               tmr_load = 1'b1;
            end else if (shr_stb_i && dat_cyc_i) begin
               state_d = ST_DECIDE;
            end
         end
         ST_IFETCH: begin
            if (!shr_stb_i)    state_d = ST_IDLE;
            else if (tmr_done) state_d = ST_DECIDE;
         end
         ST_DECIDE: begin
            if (!shr_stb_i) begin
               state_d = ST_IDLE;
            end else if (dat_cyc_i && dat_we_i) begin
               state_d = ST_WSETUP;
            end else if (dat_cyc_i) begin
               state_d  = ST_DREAD;
               tmr_load = 1'b1;
            end else begin
               state_d = ST_ACK;
            end
         end
         ST_DREAD: begin
            if (!shr_stb_i)    state_d = ST_IDLE;
            else if (tmr_done) state_d = ST_ACK;
         end
         ST_WSETUP: begin
            state_d  = ST_WPULSE;
            tmr_load = 1'b1;
            tmr_val  = WR_LOAD;
         end
         ST_WPULSE: begin
            if (tmr_done) state_d = ST_WHOLD;
         end
         ST_WHOLD: begin
            state_d = (wr_drop_q || !shr_stb_i) ? ST_IDLE : ST_ACK;
         end
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Read-data latches, write address/data capture and the sticky strobe-drop flag
   always_ff @(posedge sys_clk_i or negedge sys_res_ni) begin
      if (!sys_res_ni) begin
         ins_dat_o <= '0;
         dat_dat_o <= '0;
         wr_adr_q  <= '0;
         wr_dat_q  <= '0;
         wr_drop_q <= 1'b0;
      end else begin
         if (state_q == ST_IFETCH && tmr_done && shr_stb_i) ins_dat_o <= mem_dat_i;
         if (state_q == ST_DREAD  && tmr_done && shr_stb_i) dat_dat_o <= mem_dat_i;
         if (state_q == ST_DECIDE) begin
            wr_adr_q  <= dat_adr_i;
            wr_dat_q  <= dat_dat_i;
            wr_drop_q <= 1'b0;
         end else if ((state_q == ST_WSETUP || state_q == ST_WPULSE ||
                       state_q == ST_WHOLD) && !shr_stb_i) begin
            wr_drop_q <= 1'b1;
         end
      end
   end

   // SRAM strobes and acknowledge decoded from state; writes use captured address/data
   always_comb begin
      shr_ack_o = 1'b0;
      mem_ce_no = 1'b1;
      mem_oe_no = 1'b1;
      mem_we_no = 1'b1;
      mem_adr_o = '0;
      mem_dat_o = '0;
      case (state_q)
         ST_IFETCH: begin
            mem_adr_o = ins_mem_adr;
            mem_ce_no = 1'b0;
            mem_oe_no = 1'b0;
         end
         ST_DREAD: begin
            mem_adr_o = dat_adr_i;
            mem_ce_no = 1'b0;
            mem_oe_no = 1'b0;
         end
         ST_WSETUP, ST_WHOLD: begin
            mem_adr_o = wr_adr_q;
            mem_dat_o = wr_dat_q;
            mem_ce_no = 1'b0;
         end
         ST_WPULSE: begin
            mem_adr_o = wr_adr_q;
            mem_dat_o = wr_dat_q;
            mem_ce_no = 1'b0;
            mem_we_no = 1'b0;
         end
         ST_ACK:  shr_ack_o = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_j1a_mem_responder.sv
// tb/tb_j1a_mem_responder.sv - self-checking bench for j1a_mem_responder
module tb_j1a_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stb [2];
   logic        ins_cyc [2];
   logic        force_cyc [2];
   logic        force_we [2];
   logic        dat_cyc [2];
   logic        dat_we [2];
   logic [12:0] ins_adr [2];
   logic [14:0] dat_adr [2];
   logic [15:0] wdat [2];
   logic        ack [2];
   logic [15:0] ins_dat [2];
   logic [15:0] dat_dat [2];
   logic [14:0] mem_adr [2];
   logic [15:0] mem_wd [2];
   logic [15:0] mem_rd [2];
   logic        ce [2];
   logic        oe [2];
   logic        we [2];

   logic [15:0] sram    [2][32768];
   logic [15:0] mdl_mem [2][32768];
   logic [15:0] exp_ins [2];
   logic [15:0] exp_dat [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic int wrd(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   function automatic int wwr(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   function automatic logic [14:0] fadr(input int d, input logic [12:0] a);
      logic [14:0] base;
      base = (d == 0) ? 15'h0000 : 15'h7FF0;
      return base + {2'b00, a};
   endfunction

   // J1A master decode: ALU op with T<-[T] is a fetch, with N->[T] a store
   function automatic logic dec_cyc(input logic [15:0] w);
      return (w[15:13] == 3'b011) && ((w[11:8] == 4'hC) || w[5]);
   endfunction

   function automatic logic dec_we(input logic [15:0] w);
      return (w[15:13] == 3'b011) && w[5];
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_master
      assign dat_cyc[g] = ins_cyc[g] ? dec_cyc(ins_dat[g]) : force_cyc[g];
      assign dat_we[g]  = ins_cyc[g] ? dec_we(ins_dat[g])  : force_we[g];
      assign mem_rd[g]  = sram[g][mem_adr[g]];
   end

   j1a_mem_responder #(.WAIT_RD(2), .WAIT_WR(2), .INS_BASE(15'h0000)) u_dut_a (
      .sys_clk_i(clk), .sys_res_ni(rst_n), .shr_stb_i(stb[0]), .shr_ack_o(ack[0]),
      .ins_cyc_i(ins_cyc[0]), .ins_adr_i(ins_adr[0]), .ins_dat_o(ins_dat[0]),
      .dat_cyc_i(dat_cyc[0]), .dat_we_i(dat_we[0]), .dat_adr_i(dat_adr[0]),
      .dat_dat_i(wdat[0]), .dat_dat_o(dat_dat[0]), .mem_adr_o(mem_adr[0]),
      .mem_dat_o(mem_wd[0]), .mem_dat_i(mem_rd[0]), .mem_ce_no(ce[0]),
      .mem_oe_no(oe[0]), .mem_we_no(we[0]));

   j1a_mem_responder #(.WAIT_RD(0), .WAIT_WR(0), .INS_BASE(15'h7FF0)) u_dut_b (
      .sys_clk_i(clk), .sys_res_ni(rst_n), .shr_stb_i(stb[1]), .shr_ack_o(ack[1]),
      .ins_cyc_i(ins_cyc[1]), .ins_adr_i(ins_adr[1]), .ins_dat_o(ins_dat[1]),
      .dat_cyc_i(dat_cyc[1]), .dat_we_i(dat_we[1]), .dat_adr_i(dat_adr[1]),
      .dat_dat_i(wdat[1]), .dat_dat_o(dat_dat[1]), .mem_adr_o(mem_adr[1]),
      .mem_dat_o(mem_wd[1]), .mem_dat_i(mem_rd[1]), .mem_ce_no(ce[1]),
      .mem_oe_no(oe[1]), .mem_we_no(we[1]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock; sample mid-cycle, commit SRAM writes and check strobe exclusivity
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("oe_we_exclusive", {31'b0, oe[d] | we[d]}, 32'h1);
         if (!ce[d] && !we[d]) sram[d][mem_adr[d]] = mem_wd[d];
      end
   endtask

   task automatic idle_inputs(input int d);
      stb[d] = 1'b0; ins_cyc[d] = 1'b0; force_cyc[d] = 1'b0; force_we[d] = 1'b0;
   endtask

   task automatic run_txn(input int d, input logic icyc, input logic fcyc, input logic fwe,
                          input logic [12:0] iadr, input logic [14:0] dadr, input logic [15:0] wd,
                          output int lat, output logic [31:0] oe_mask, output logic [31:0] we_mask,
                          output logic [14:0] adr1);
      stb[d] = 1'b1; ins_cyc[d] = icyc; force_cyc[d] = fcyc; force_we[d] = fwe;
      ins_adr[d] = iadr; dat_adr[d] = dadr; wdat[d] = wd;
      lat = -1; oe_mask = '0; we_mask = '0; adr1 = '0;
      for (int i = 1; i <= 40 && lat < 0; i++) begin
         tick();
         if (i < 32 && !oe[d]) oe_mask[i] = 1'b1;
         if (i < 32 && !we[d]) we_mask[i] = 1'b1;
         if (i == 1) adr1 = mem_adr[d];
         if (ack[d]) lat = i;
      end
      idle_inputs(d);
      tick();
      tick();
   endtask

   // Reference: phase lengths add up to the ack clock; memory effects applied in order
   task automatic model(input int d, input logic icyc, input logic fcyc, input logic fwe,
                        input logic [12:0] iadr, input logic [14:0] dadr, input logic [15:0] wd,
                        output int lat, output logic is_wr);
      int fetch_clks, data_clks;
      logic c, e;
      fetch_clks = 0;
      if (icyc) begin
         exp_ins[d] = mdl_mem[d][fadr(d, iadr)];
         c = dec_cyc(exp_ins[d]);
         e = dec_we(exp_ins[d]);
         fetch_clks = wrd(d) + 1;
      end else begin
         c = fcyc;
         e = fwe;
      end
      is_wr = c & e;
      if (!c) begin
         data_clks = 0;
      end else if (e) begin
         data_clks = 1 + (wwr(d) + 1) + 1;
         mdl_mem[d][dadr] = wd;
      end else begin
         data_clks = wrd(d) + 1;
         exp_dat[d] = mdl_mem[d][dadr];
      end
      lat = fetch_clks + 1 + data_clks + 1;
   endtask

   typedef struct {
      logic        icyc, fcyc, fwe;
      logic [12:0] iadr;
      logic [15:0] iword;
      logic [14:0] dadr;
      logic [15:0] dword;
      logic [15:0] wd;
      int          lat;
      logic [31:0] oem, wem;
      logic [15:0] eins, edat;
      logic        wchk;
   } vec_t;

   initial begin
      vec_t        vt [6];
      int          lat, mlat;
      logic [31:0] oem, wem;
      logic [14:0] adr1;
      logic        seen, seen_ce, is_wr;
      logic [15:0] w;

      vt[0] = '{1'b1, 1'b0, 1'b0, 13'h0010, 16'h8005, 15'h0000, 16'h0000, 16'h0000, 5,  32'h0E,  32'h000, 16'h8005, 16'h0000, 1'b0};
      vt[1] = '{1'b1, 1'b0, 1'b0, 13'h0011, 16'h6C00, 15'h1234, 16'hBEEF, 16'h0000, 8,  32'hEE,  32'h000, 16'h6C00, 16'hBEEF, 1'b0};
      vt[2] = '{1'b1, 1'b0, 1'b0, 13'h0012, 16'h6020, 15'h0100, 16'h0000, 16'hCAFE, 10, 32'h0E,  32'h1C0, 16'h6020, 16'hBEEF, 1'b1};
      vt[3] = '{1'b0, 1'b1, 1'b0, 13'h0000, 16'h0000, 15'h0200, 16'h1357, 16'h0000, 5,  32'h1C,  32'h000, 16'h6020, 16'h1357, 1'b0};
      vt[4] = '{1'b0, 1'b1, 1'b1, 13'h0000, 16'h0000, 15'h0300, 16'h0000, 16'h2468, 7,  32'h00,  32'h038, 16'h6020, 16'h1357, 1'b1};
      vt[5] = '{1'b1, 1'b0, 1'b0, 13'h1FFF, 16'h6000, 15'h7FFF, 16'h0000, 16'h0000, 5,  32'h0E,  32'h000, 16'h6000, 16'h1357, 1'b0};

      for (int a = 0; a < 32768; a++) begin
         sram[0][a] = 16'(a * 3);
         sram[1][a] = 16'(a * 5 + 1);
         mdl_mem[0][a] = 16'(a * 3);
         mdl_mem[1][a] = 16'(a * 5 + 1);
      end
      for (int d = 0; d < 2; d++) begin
         idle_inputs(d);
         ins_adr[d] = '0; dat_adr[d] = '0; wdat[d] = '0;
         exp_ins[d] = '0; exp_dat[d] = '0;
      end

      // Reset values
      rst_n = 1'b0;
      tick();
      tick();
      check("rst_ack",     {31'b0, ack[0]}, 32'h0);
      check("rst_ins_dat", {16'b0, ins_dat[0]}, 32'h0);
      check("rst_dat_dat", {16'b0, dat_dat[0]}, 32'h0);
      check("rst_strobes", {29'b0, ce[0], oe[0], we[0]}, 32'h7);
      check("rst_mem_adr", {17'b0, mem_adr[0]}, 32'h0);
      check("rst_mem_dat", {16'b0, mem_wd[0]}, 32'h0);
      rst_n = 1'b1;
      tick();

      // Directed vectors on the WAIT=2 instance
      for (int r = 0; r < 6; r++) begin
         if (vt[r].icyc) begin
            sram[0][vt[r].iadr] = vt[r].iword;
            mdl_mem[0][vt[r].iadr] = vt[r].iword;
         end
         sram[0][vt[r].dadr] = vt[r].dword;
         mdl_mem[0][vt[r].dadr] = vt[r].dword;
         run_txn(0, vt[r].icyc, vt[r].fcyc, vt[r].fwe, vt[r].iadr, vt[r].dadr, vt[r].wd,
                 lat, oem, wem, adr1);
         check($sformatf("vec%0d_latency", r), lat, vt[r].lat);
         check($sformatf("vec%0d_oe_clocks", r), oem, vt[r].oem);
         check($sformatf("vec%0d_we_clocks", r), wem, vt[r].wem);
         check($sformatf("vec%0d_ins_dat", r), {16'b0, ins_dat[0]}, {16'b0, vt[r].eins});
         check($sformatf("vec%0d_dat_dat", r), {16'b0, dat_dat[0]}, {16'b0, vt[r].edat});
         if (vt[r].wchk) begin
            check($sformatf("vec%0d_sram_wr", r), {16'b0, sram[0][vt[r].dadr]}, {16'b0, vt[r].wd});
            mdl_mem[0][vt[r].dadr] = vt[r].wd;
         end
      end
      exp_ins[0] = 16'h6000;
      exp_dat[0] = 16'h1357;

      // Base wrap on the WAIT=0 instance
      sram[1][15'h0010] = 16'hA5A5;
      mdl_mem[1][15'h0010] = 16'hA5A5;
      run_txn(1, 1'b1, 1'b0, 1'b0, 13'h0020, 15'h0000, 16'h0000, lat, oem, wem, adr1);
      check("wrap_mem_adr", {17'b0, adr1}, 32'h0010);
      check("wrap_ins_dat", {16'b0, ins_dat[1]}, 32'hA5A5);
      check("wrap_latency", lat, 3);
      exp_ins[1] = 16'hA5A5;

      // STB dropped during DREAD: abort next clock, no ack, no latch
      sram[0][15'h0040] = 16'h6C00;  mdl_mem[0][15'h0040] = 16'h6C00;
      sram[0][15'h0500] = 16'hDEAD;  mdl_mem[0][15'h0500] = 16'hDEAD;
      stb[0] = 1'b1; ins_cyc[0] = 1'b1; ins_adr[0] = 13'h0040; dat_adr[0] = 15'h0500;
      seen = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         seen |= ack[0];
      end
      check("drop_rd_in_dread", {31'b0, oe[0]}, 32'h0);
      idle_inputs(0);
      tick();
      check("drop_rd_idle_next", {30'b0, ce[0], oe[0]}, 32'h3);
      for (int i = 0; i < 5; i++) begin
         tick();
         seen |= ack[0];
      end
      check("drop_rd_no_ack", {31'b0, seen}, 32'h0);
      check("drop_rd_no_latch", {16'b0, dat_dat[0]}, 32'h1357);
      check("drop_rd_ins_dat", {16'b0, ins_dat[0]}, 32'h6C00);
      exp_ins[0] = 16'h6C00;

      // STB with no CYC: no SRAM activity, no ack
      stb[0] = 1'b1;
      seen = 1'b0; seen_ce = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         seen |= ack[0];
         seen_ce |= !ce[0];
      end
      idle_inputs(0);
      tick();
      check("nocyc_no_ack", {31'b0, seen}, 32'h0);
      check("nocyc_no_ce", {31'b0, seen_ce}, 32'h0);

      // STB dropped mid-WPULSE: write completes, no ack
      sram[0][15'h0041] = 16'h6020;  mdl_mem[0][15'h0041] = 16'h6020;
      sram[0][15'h0600] = 16'h0000;
      stb[0] = 1'b1; ins_cyc[0] = 1'b1; ins_adr[0] = 13'h0041; dat_adr[0] = 15'h0600; wdat[0] = 16'h7777;
      seen = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         tick();
         seen |= ack[0];
      end
      check("drop_wr_in_wpulse", {31'b0, we[0]}, 32'h0);
      idle_inputs(0);
      for (int i = 0; i < 8; i++) begin
         tick();
         seen |= ack[0];
      end
      check("drop_wr_no_ack", {31'b0, seen}, 32'h0);
      check("drop_wr_sram", {16'b0, sram[0][15'h0600]}, 32'h7777);
      check("drop_wr_we_idle", {31'b0, we[0]}, 32'h1);
      mdl_mem[0][15'h0600] = 16'h7777;
      exp_ins[0] = 16'h6020;

      // Asynchronous reset mid-WPULSE
      sram[0][15'h0042] = 16'h6020;  mdl_mem[0][15'h0042] = 16'h6020;
      stb[0] = 1'b1; ins_cyc[0] = 1'b1; ins_adr[0] = 13'h0042; dat_adr[0] = 15'h0700; wdat[0] = 16'h1111;
      for (int i = 1; i <= 6; i++) tick();
      check("arst_pre_we", {31'b0, we[0]}, 32'h0);
      rst_n = 1'b0;
      #1;
      check("arst_we_high", {31'b0, we[0]}, 32'h1);
      check("arst_ack_low", {31'b0, ack[0]}, 32'h0);
      check("arst_ins_dat", {16'b0, ins_dat[0]}, 32'h0);
      check("arst_ce_high", {31'b0, ce[0]}, 32'h1);
      idle_inputs(0);
      tick();
      rst_n = 1'b1;
      tick();
      sram[0][15'h0700] = 16'h1111;
      mdl_mem[0][15'h0700] = 16'h1111;
      for (int d = 0; d < 2; d++) begin
         exp_ins[d] = '0;
         exp_dat[d] = '0;
      end

      // Randomised transactions against the reference model
      for (int n = 0; n < 80; n++) begin
         int          d, kind;
         logic        icyc, fcyc, fwe;
         logic [12:0] iadr;
         logic [14:0] dadr;
         logic [15:0] wd;
         d    = int'($urandom_range(1, 0));
         kind = int'($urandom_range(3, 0));
         iadr = 13'($urandom);
         dadr = 15'($urandom);
         wd   = 16'($urandom);
         w    = 16'($urandom);
         icyc = (kind != 3);
         fcyc = (kind == 3);
         fwe  = (kind == 3) && ($urandom_range(1, 0) == 1);
         case (kind)
            0: w[15] = 1'b1;
            1: begin w[15:13] = 3'b011; w[11:8] = 4'hC; w[5] = 1'b0; end
            2: begin w[15:13] = 3'b011; w[5] = 1'b1; end
            default: ;
         endcase
         if (icyc) begin
            sram[d][fadr(d, iadr)] = w;
            mdl_mem[d][fadr(d, iadr)] = w;
         end
         model(d, icyc, fcyc, fwe, iadr, dadr, wd, mlat, is_wr);
         run_txn(d, icyc, fcyc, fwe, iadr, dadr, wd, lat, oem, wem, adr1);
         check($sformatf("rnd%0d_latency", n), lat, mlat);
         check($sformatf("rnd%0d_ins_dat", n), {16'b0, ins_dat[d]}, {16'b0, exp_ins[d]});
         check($sformatf("rnd%0d_dat_dat", n), {16'b0, dat_dat[d]}, {16'b0, exp_dat[d]});
         if (is_wr)
            check($sformatf("rnd%0d_sram_wr", n), {16'b0, sram[d][dadr]}, {16'b0, mdl_mem[d][dadr]});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
